// File: rtl/vga_timing_pkg.sv
// Shared constants for the 640x480@60 raster timing generator: default
// porch/sync widths, total-length derivation and sync window bounds.
package vga_timing_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int CW_DEF       = 10;

  // Total positions along one axis: visible + front porch + sync + back porch.
  function automatic int scan_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // First counter value inside the sync pulse.
  function automatic int sync_start(input int active, input int fp);
    return active + fp;
  endfunction

  // First counter value past the sync pulse.
  function automatic int sync_end(input int active, input int fp, input int sync);
    return active + fp + sync;
  endfunction

  localparam int H_TOTAL_DEF  = scan_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int V_TOTAL_DEF  = scan_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);
  localparam int HS_START_DEF = sync_start(H_ACTIVE_DEF, H_FP_DEF);
  localparam int HS_END_DEF   = sync_end(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF);
  localparam int VS_START_DEF = sync_start(V_ACTIVE_DEF, V_FP_DEF);
  localparam int VS_END_DEF   = sync_end(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF);

endpackage

// File: rtl/vga_scan_counter.sv
// Wrapping horizontal/vertical scan position pair. Holds the position that
// the next enabled step will present; advances one pixel per enabled step.
module vga_scan_counter #(
  parameter int CW      = 10,
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int INIT_X  = 0,
  parameter int INIT_Y  = 0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          pix_en,
  output logic [CW-1:0] hc,
  output logic [CW-1:0] vc
);

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] X_INIT = CW'(INIT_X);
  localparam logic [CW-1:0] Y_INIT = CW'(INIT_Y);

  // Advance the position, wrapping at end of line and end of frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      hc <= X_INIT;
      vc <= Y_INIT;
    end else if (pix_en) begin
      if (hc == H_LAST) begin
        hc <= '0;
        if (vc == V_LAST) vc <= '0;
        else              vc <= vc + 1'b1;
      end else begin
        hc <= hc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 video timing generator: registered position, active flag,
// sync pulses and line/frame strobes. Optional prefetch position port is
// built when VGA_TIMING_GEN_PREFETCH_EN is defined.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CW       = CW_DEF,
  parameter int   LEAD     = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          pix_en,
  output logic [CW-1:0] video_x,
  output logic [CW-1:0] video_y,
  output logic          video_active,
  output logic          video_hs,
  output logic          video_vs,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_GEN_PREFETCH_EN
  ,
  output logic [CW-1:0] pre_x,
  output logic [CW-1:0] pre_y,
  output logic          pre_active
`endif
);

  localparam int H_TOTAL = scan_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = scan_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG_C = CW'(sync_start(H_ACTIVE, H_FP));
  localparam logic [CW-1:0] HS_END_C = CW'(sync_end(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [CW-1:0] VS_BEG_C = CW'(sync_start(V_ACTIVE, V_FP));
  localparam logic [CW-1:0] VS_END_C = CW'(sync_end(V_ACTIVE, V_FP, V_SYNC));

  // Elaboration-time sanity: counters must hold the totals, lead must fit a line.
  if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_cw
    $error("CW too narrow for scan totals");
  end
  if (LEAD < 1 || LEAD > H_TOTAL - 1) begin : g_bad_lead
    $error("LEAD out of range");
  end

  logic [CW-1:0] hc;
  logic [CW-1:0] vc;

  vga_scan_counter #(
    .CW(CW), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .INIT_X(0), .INIT_Y(0)
  ) u_main_cnt (
    .clock(clock), .reset(reset), .pix_en(pix_en), .hc(hc), .vc(vc)
  );

  // Present the current scan position and decode its timing flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      video_x      <= '0;
      video_y      <= '0;
      video_active <= 1'b0;
      video_hs     <= ~HS_POL;
      video_vs     <= ~VS_POL;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
    end else if (pix_en) begin
      video_x      <= hc;
      video_y      <= vc;
      video_active <= (hc < H_ACT_C) && (vc < V_ACT_C);
      video_hs     <= ((hc >= HS_BEG_C) && (hc < HS_END_C)) ? HS_POL : ~HS_POL;
      video_vs     <= ((vc >= VS_BEG_C) && (vc < VS_END_C)) ? VS_POL : ~VS_POL;
      line_start   <= (hc == '0);
      frame_start  <= (hc == '0) && (vc == '0);
    end else begin
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
    end
  end

`ifdef VGA_TIMING_GEN_PREFETCH_EN
  logic [CW-1:0] pre_hc;
  logic [CW-1:0] pre_vc;

  // Lead counter starts LEAD steps ahead of the main one and stays locked to it.
  vga_scan_counter #(
    .CW(CW), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
    .INIT_X(LEAD % H_TOTAL), .INIT_Y((LEAD / H_TOTAL) % V_TOTAL)
  ) u_pre_cnt (
    .clock(clock), .reset(reset), .pix_en(pix_en), .hc(pre_hc), .vc(pre_vc)
  );

  // Present the look-ahead position alongside the main outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      pre_x      <= '0;
      pre_y      <= '0;
      pre_active <= 1'b0;
    end else if (pix_en) begin
      pre_x      <= pre_hc;
      pre_y      <= pre_vc;
      pre_active <= (pre_hc < H_ACT_C) && (pre_vc < V_ACT_C);
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen using a reduced raster so whole
// frames fit in a short run. Expected values come from a step-count model.
module tb_vga_timing_gen;

  localparam int   CW   = 10;
  localparam int   HA   = 20, HFP = 3, HSY = 5, HBP = 4;
  localparam int   VA   = 12, VFP = 2, VSY = 2, VBP = 3;
  localparam logic HSP  = 1'b1;
  localparam logic VSP  = 1'b0;
  localparam int   LEAD = 2;
  localparam int   HT    = HA + HFP + HSY + HBP;
  localparam int   VT    = VA + VFP + VSY + VBP;
  localparam int   FRAME = HT * VT;
  localparam int   OW    = 2 * CW + 5;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          pix_en = 1'b0;
  logic [CW-1:0] video_x, video_y;
  logic          video_active, video_hs, video_vs, line_start, frame_start;
`ifdef VGA_TIMING_GEN_PREFETCH_EN
  logic [CW-1:0] pre_x, pre_y;
  logic          pre_active;
`endif

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(HSP), .VS_POL(VSP), .CW(CW), .LEAD(LEAD)
  ) dut (
    .clock(clock), .reset(reset), .pix_en(pix_en),
    .video_x(video_x), .video_y(video_y), .video_active(video_active),
    .video_hs(video_hs), .video_vs(video_vs),
    .line_start(line_start), .frame_start(frame_start)
`ifdef VGA_TIMING_GEN_PREFETCH_EN
    , .pre_x(pre_x), .pre_y(pre_y), .pre_active(pre_active)
`endif
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: number of enabled steps since reset release (-1 = none yet).
  int            steps = -1;
  logic [CW-1:0] ex = '0, ey = '0;
  logic          ea = 1'b0, ehs = ~HSP, evs = ~VSP, els = 1'b0, efs = 1'b0;

  task automatic model_edge(input logic r, input logic en);
    int pos;
    if (r) begin
      steps = -1;
      ex = '0; ey = '0; ea = 1'b0; ehs = ~HSP; evs = ~VSP; els = 1'b0; efs = 1'b0;
    end else if (en) begin
      steps = steps + 1;
      pos = steps % FRAME;
      ex  = CW'(pos % HT);
      ey  = CW'(pos / HT);
      ea  = (pos % HT < HA) && (pos / HT < VA);
      ehs = (pos % HT >= HA + HFP && pos % HT < HA + HFP + HSY) ? HSP : ~HSP;
      evs = (pos / HT >= VA + VFP && pos / HT < VA + VFP + VSY) ? VSP : ~VSP;
      els = (pos % HT == 0);
      efs = (pos == 0);
    end else begin
      els = 1'b0;
      efs = 1'b0;
    end
  endtask

  function automatic logic [OW-1:0] obs();
    return {video_x, video_y, video_active, video_hs, video_vs, line_start, frame_start};
  endfunction

  function automatic logic [OW-1:0] expv();
    return {ex, ey, ea, ehs, evs, els, efs};
  endfunction

  function automatic logic [2*CW:0] pre_exp();
    int p;
    p = (steps + LEAD) % FRAME;
    return {CW'(p % HT), CW'(p / HT), logic'((p % HT < HA) && (p / HT < VA))};
  endfunction

  task automatic tick(input logic r, input logic en);
    @(negedge clock);
    reset  = r;
    pix_en = en;
    @(posedge clock);
    model_edge(r, en);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'($urandom_range(0, 1)));
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++;
        $display("FAIL reset_values cyc=%0d got=%h want=%h", i, obs(), expv());
      end
`ifdef VGA_TIMING_GEN_PREFETCH_EN
      n_cmp++;
      if (pre_active !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_pre_active got=%b want=0", pre_active);
      end
`endif
    end
  endtask

  task automatic test_first_step();
    tick(1'b0, 1'b1);
    n_cmp++;
    if ({video_x, video_y} !== {CW'(0), CW'(0)}) begin
      n_bad++;
      $display("FAIL first_pos got=(%0d,%0d) want=(0,0)", video_x, video_y);
    end
    n_cmp++;
    if ({video_active, line_start, frame_start, video_hs, video_vs} !== {3'b111, ~HSP, ~VSP}) begin
      n_bad++;
      $display("FAIL first_flags got=%b%b%b%b%b want=111%b%b", video_active, line_start,
               frame_start, video_hs, video_vs, ~HSP, ~VSP);
    end
  endtask

  task automatic test_frame_period();
    int fs_at = -1, hs_cnt = 0, hs_first = -1, vs_cnt = 0, act_cnt = 0, wrap_seen = 0;
    logic [CW-1:0] px, py;
    for (int i = 0; i < FRAME + 4; i++) begin
      px = video_x; py = video_y;
      tick(1'b0, 1'b1);
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++;
        $display("FAIL frame_run i=%0d got=%h want=%h", i, obs(), expv());
      end
`ifdef VGA_TIMING_GEN_PREFETCH_EN
      n_cmp++;
      if ({pre_x, pre_y, pre_active} !== pre_exp()) begin
        n_bad++;
        $display("FAIL prefetch i=%0d got=(%0d,%0d,%b) want=%h", i, pre_x, pre_y, pre_active, pre_exp());
      end
`endif
      if (frame_start && fs_at < 0) fs_at = i;
      if (i < FRAME - 1 && video_y == 0 && video_hs == HSP) begin
        if (hs_first < 0) hs_first = int'(video_x);
        hs_cnt++;
      end
      if (i < FRAME && video_vs == VSP) vs_cnt++;
      if (i < FRAME && video_active) act_cnt++;
      if (px == CW'(HT - 1) && py == CW'(VT - 1)) begin
        wrap_seen++;
        n_cmp++;
        if ({video_x, video_y, frame_start} !== {CW'(0), CW'(0), 1'b1}) begin
          n_bad++;
          $display("FAIL frame_wrap got=(%0d,%0d,fs=%b) want=(0,0,fs=1)", video_x, video_y, frame_start);
        end
      end
    end
    n_cmp++;
    if (fs_at != FRAME - 1) begin n_bad++; $display("FAIL fs_period got=%0d want=%0d", fs_at + 1, FRAME); end
    n_cmp++;
    if (hs_cnt != HSY || hs_first != HA + HFP) begin
      n_bad++;
      $display("FAIL hs_window got=%0d@%0d want=%0d@%0d", hs_cnt, hs_first, HSY, HA + HFP);
    end
    n_cmp++;
    if (vs_cnt != VSY * HT) begin n_bad++; $display("FAIL vs_window got=%0d want=%0d", vs_cnt, VSY * HT); end
    n_cmp++;
    if (act_cnt != HA * VA) begin n_bad++; $display("FAIL active_count got=%0d want=%0d", act_cnt, HA * VA); end
    n_cmp++;
    if (wrap_seen != 1) begin n_bad++; $display("FAIL wrap_reached got=%0d want=1", wrap_seen); end
  endtask

  task automatic test_toggle_en();
    int ls_cnt = 0, fs_cnt = 0, dbl = 0;
    logic prev_ls = 1'b0;
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    for (int c = 0; c < 2 * FRAME; c++) begin
      tick(1'b0, logic'(c % 2 == 0));
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++;
        $display("FAIL toggle_run c=%0d got=%h want=%h", c, obs(), expv());
      end
      if (line_start) ls_cnt++;
      if (frame_start) fs_cnt++;
      if (line_start && prev_ls) dbl++;
      prev_ls = line_start;
    end
    n_cmp++;
    if (ls_cnt != VT || dbl != 0 || fs_cnt != 1) begin
      n_bad++;
      $display("FAIL toggle_strobes got=ls%0d/dbl%0d/fs%0d want=ls%0d/dbl0/fs1", ls_cnt, dbl, fs_cnt, VT);
    end
    tick(1'b0, 1'b1);
    n_cmp++;
    if ({video_x, video_y, frame_start} !== {CW'(0), CW'(0), 1'b1}) begin
      n_bad++;
      $display("FAIL toggle_frame_len got=(%0d,%0d,fs=%b) want=(0,0,fs=1)", video_x, video_y, frame_start);
    end
  endtask

  task automatic test_random_en();
    tick(1'b1, 1'b0);
    for (int c = 0; c < 3 * FRAME; c++) begin
      tick(1'b0, logic'($urandom_range(0, 3) != 0));
      n_cmp++;
      if (obs() !== expv()) begin
        n_bad++;
        $display("FAIL random_run c=%0d got=%h want=%h", c, obs(), expv());
      end
`ifdef VGA_TIMING_GEN_PREFETCH_EN
      if (steps >= 0) begin
        n_cmp++;
        if ({pre_x, pre_y, pre_active} !== pre_exp()) begin
          n_bad++;
          $display("FAIL random_prefetch c=%0d got=(%0d,%0d,%b) want=%h", c, pre_x, pre_y, pre_active, pre_exp());
        end
      end
`endif
    end
  endtask

  task automatic test_mid_reset();
    int budget = 2 * FRAME;
    while (!(video_x == CW'(HT / 2) && video_y == CW'(VT / 2)) && budget > 0) begin
      tick(1'b0, 1'b1);
      budget--;
    end
    n_cmp++;
    if (budget == 0) begin
      n_bad++;
      $display("FAIL midreset_reach got=(%0d,%0d) want=(%0d,%0d)", video_x, video_y, HT / 2, VT / 2);
    end
    tick(1'b1, 1'b1);
    n_cmp++;
    if (obs() !== {CW'(0), CW'(0), 1'b0, ~HSP, ~VSP, 2'b00}) begin
      n_bad++;
      $display("FAIL midreset_values got=%h want=%h", obs(), {CW'(0), CW'(0), 1'b0, ~HSP, ~VSP, 2'b00});
    end
    tick(1'b0, 1'b1);
    n_cmp++;
    if ({video_x, video_y, video_active, frame_start} !== {CW'(0), CW'(0), 2'b11}) begin
      n_bad++;
      $display("FAIL midreset_restart got=(%0d,%0d,a=%b,fs=%b) want=(0,0,1,1)", video_x, video_y,
               video_active, frame_start);
    end
  endtask

  initial begin
    test_reset();
    test_first_step();
    test_frame_period();
    test_toggle_en();
    test_random_en();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
